// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the E-stage multiply/divide unit.
//   mdu_op_e    : MDUOp encodings (also decoded by the hazard unit)
//   mdu_state_e : latency FSM states
//   CNT_W       : width of the latency down-counter (latencies 1..255)
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/e_mdu_calc.sv
// ---------------------------------------------------------------------------
// e_mdu_calc
// Combinational arithmetic core of the MDU, evaluated on latched operands.
// Ports:
//   a, b      in  : latched rs / rt operands
//   op        in  : latched operation
//   base      in  : current {HI,LO}, accumulate base for MADD/MADDU
//   result    out : {HI,LO} value to commit on completion
//   div_zero  out : divide op with b == 0 (commit suppressed by the top)
// MADD/MADDU are always computed here; whether they may launch at all is
// decided in the top (macro MDU_MADD_EN).
// ---------------------------------------------------------------------------
module e_mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  mdu_op_e            op,
    input  logic [2*WIDTH-1:0] base,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, bu_safe;
    logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Signed product via explicit sign extension to full 2*WIDTH.
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. MIN / -1 falls out naturally:
    // |MIN| wraps back to MIN as the quotient and the remainder is 0.
    assign a_neg   = a[WIDTH-1];
    assign b_neg   = b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    // Divisor forced nonzero so the datapath never divides by zero; the
    // result is discarded in that case anyway.
    assign b_safe  = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign bu_safe = (b == '0)     ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign q_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s     = a_neg ? -r_mag : r_mag;
    assign q_u     = a / bu_safe;
    assign r_u     = a % bu_safe;

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                result   = {r_s, q_s};
                div_zero = (b == '0);
            end
            MDU_DIVU: begin
                result   = {r_u, q_u};
                div_zero = (b == '0);
            end
            MDU_MADD:  result = base + prod_s;
            MDU_MADDU: result = base + prod_u;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu
// E-stage multiply/divide unit with fixed, parametrised latency. Owns the
// HI/LO registers and services MFHI/MFLO/MTHI/MTLO.
// Ports:
//   clk     in  : rising-edge clock
//   reset   in  : synchronous active-high reset
//   start   in  : one-cycle launch pulse for an arithmetic MDUOp
//   MDUOp   in  : operation code (mdu_pkg::mdu_op_e)
//   A, B    in  : rs / rt operands
//   busy    out : operation in flight (exactly LAT cycles)
//   HI, LO  out : architectural HI/LO
//   MDUOut  out : HI on MFHI, LO on MFLO, else 0 (no in-flight bypass)
// Optional feature: define MDU_MADD_EN to make MADD/MADDU valid launch ops;
// otherwise those encodings are no-ops.
// ---------------------------------------------------------------------------
module e_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUOut
);

    mdu_state_e         state, state_d;
    logic [CNT_W-1:0]   cnt;
    mdu_op_e            op_in, op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] result;
    logic               div_zero;
    logic               is_mul, is_div, launch, done;

    assign op_in = mdu_op_e'(MDUOp);

    always_comb begin
        is_div = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
`ifdef MDU_MADD_EN
        is_mul = (op_in == MDU_MULT) || (op_in == MDU_MULTU) ||
                 (op_in == MDU_MADD) || (op_in == MDU_MADDU);
`else
        is_mul = (op_in == MDU_MULT) || (op_in == MDU_MULTU);
`endif
    end

    assign launch = (state == IDLE) && start && (is_mul || is_div);
    assign done   = (state == BUSY) && (cnt == CNT_W'(1));
    assign busy   = (state == BUSY);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (launch) state_d = BUSY;
            BUSY:    if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_d;
            if (launch)
                cnt <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            else if (state == BUSY)
                cnt <= cnt - CNT_W'(1);

            if (done) begin
                if (!div_zero) {HI, LO} <= result;
            end else if (state == IDLE && !start) begin
                if (op_in == MDU_MTHI) HI <= A;
                if (op_in == MDU_MTLO) LO <= A;
            end
        end
    end

    // NOTE: operand latches carry no reset; they are only consumed after a
    // launch has written them, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (launch) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_in;
        end
    end

    e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .base     ({HI, LO}),
        .result   (result),
        .div_zero (div_zero)
    );

    always_comb begin
        MDUOut = '0;
        if (op_in == MDU_MFHI)      MDUOut = HI;
        else if (op_in == MDU_MFLO) MDUOut = LO;
    end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu
// Self-checking bench for e_mdu: directed scenarios followed by randomized
// traffic, compared cycle by cycle against a transaction-level model that
// computes results with 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, mdu_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [63:0] m_res;
    bit          m_dz;

    e_mdu #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUOp  (op),
        .A      (a),
        .B      (b),
        .busy   (busy),
        .HI     (hi),
        .LO     (lo),
        .MDUOut (mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_valid(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU};
`else
        return o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
`endif
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc,
                                               output bit dz);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0]     qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        dz = 1'b0;
        case (o)
            MDU_MULT:  return sx * sy;
            MDU_MULTU: return ux * uy;
            MDU_MADD:  return acc + 64'(sx * sy);
            MDU_MADDU: return acc + 64'(ux * uy);
            MDU_DIV: begin
                if (y == 0) begin dz = 1'b1; return 64'd0; end
                q = sx / sy; r = sx % sy;
                qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            MDU_DIVU: begin
                if (y == 0) begin dz = 1'b1; return 64'd0; end
                qv = ux / uy; rv = ux % uy;
                return {rv[31:0], qv[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Advance the model by one edge from the current inputs, clock the DUT,
    // then compare all outputs.
    task automatic cycle();
        bit dz;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_dz) {m_hi, m_lo} = m_res;
        end else if (start && op_valid(op)) begin
            m_left = (op == MDU_DIV || op == MDU_DIVU) ? DIV_LAT : MUL_LAT;
            m_res  = ref_result(op, a, b, {m_hi, m_lo}, dz);
            m_dz   = dz;
        end else if (!start && op == MDU_MTHI) begin
            m_hi = a;
        end else if (!start && op == MDU_MTLO) begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
        check("busy", 64'(busy), 64'(m_left > 0));
        check("HI", 64'(hi), 64'(m_hi));
        check("LO", 64'(lo), 64'(m_lo));
        check("MDUOut", 64'(mdu_out),
              (op == MDU_MFHI) ? 64'(m_hi) : (op == MDU_MFLO) ? 64'(m_lo) : 64'd0);
    endtask

    task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        reset = 1'b0; start = s; op = o; a = x; b = y;
        cycle();
    endtask

    // Idle cycles; report how many showed busy high.
    task automatic run_idle(input int n, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, MDU_NOP, 32'h0, 32'h0);
            if (busy) nbusy++;
        end
    endtask

    initial begin
        int nb;
        reset = 1'b1; start = 1'b0; op = MDU_NOP; a = 0; b = 0;
        m_hi = 'x; m_lo = 'x; m_left = 0; m_dz = 0; m_res = 0;
        cycle(); cycle();
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // MULT -3 * 7
        drive(1'b1, MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        nb = 1;
        begin int rest; run_idle(6, rest); nb += rest; end
        check("mult_busy_cycles", 64'(nb), 64'(MUL_LAT));
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        // MULTU 0xFFFFFFFF * 2
        drive(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_idle(6, nb);
        check("multu_hi", 64'(hi), 64'd1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // DIV -7 / 2
        drive(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_idle(11, nb);
        check("div_busy_cycles", 64'(nb + 1), 64'(DIV_LAT));
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // DIVU by zero: full latency, HI/LO unchanged
        drive(1'b1, MDU_DIVU, 32'd7, 32'd0);
        run_idle(11, nb);
        check("divz_busy_cycles", 64'(nb + 1), 64'(DIV_LAT));
        check("divz_hi", 64'(hi), 64'hFFFF_FFFF);
        check("divz_lo", 64'(lo), 64'hFFFF_FFFD);

        // DIV overflow MIN / -1
        drive(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_idle(11, nb);
        check("divovf_lo", 64'(lo), 64'h8000_0000);
        check("divovf_hi", 64'(hi), 64'd0);

        // MTHI then reads
        drive(1'b0, MDU_MTHI, 32'h1234, 32'h0);
        drive(1'b0, MDU_MFHI, 32'h0, 32'h0);
        check("mfhi", 64'(mdu_out), 64'h1234);
        drive(1'b0, MDU_MFLO, 32'h0, 32'h0);
        check("mflo", 64'(mdu_out), 64'h8000_0000);

        // MTLO and restart while busy are ignored
        drive(1'b1, MDU_MULTU, 32'd3, 32'd5);
        nb = 1;
        drive(1'b0, MDU_MTLO, 32'hDEAD_BEEF, 32'h0);
        if (busy) nb++;
        drive(1'b1, MDU_MULT, 32'd9, 32'd9);
        if (busy) nb++;
        begin int rest; run_idle(6, rest); nb += rest; end
        check("busy_no_extend", 64'(nb), 64'(MUL_LAT));
        check("mtlo_ignored_lo", 64'(lo), 64'd15);
        check("mtlo_ignored_hi", 64'(hi), 64'd0);

        // Reset on cycle 3 of a DIV
        drive(1'b1, MDU_DIV, 32'd100, 32'd3);
        drive(1'b0, MDU_NOP, 32'h0, 32'h0);
        reset = 1'b1; start = 1'b0; cycle();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {32'(hi), 32'(lo)}, 64'd0);
        drive(1'b1, MDU_MULT, 32'd6, 32'd7);
        nb = 1;
        begin int rest; run_idle(12, rest); nb += rest; end
        check("post_rst_mult_cycles", 64'(nb), 64'(MUL_LAT));
        check("post_rst_mult_lo", 64'(lo), 64'd42);

        // MADDU accumulate (or no-op when the feature is absent)
        drive(1'b0, MDU_MTHI, 32'h0, 32'h0);
        drive(1'b0, MDU_MTLO, 32'hFFFF_FFFF, 32'h0);
        drive(1'b1, MDU_MADDU, 32'd1, 32'd1);
        nb = busy ? 1 : 0;
        begin int rest; run_idle(6, rest); nb += rest; end
`ifdef MDU_MADD_EN
        check("maddu_cycles", 64'(nb), 64'(MUL_LAT));
        check("maddu_hilo", {32'(hi), 32'(lo)}, 64'h0000_0001_0000_0000);
`else
        check("maddu_noop_cycles", 64'(nb), 64'd0);
        check("maddu_noop_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_FFFF_FFFF);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, rb;
            case ($urandom_range(0, 3))
                0: ra = 32'($signed($urandom_range(0, 16)) - 8);
                1: ra = 32'h8000_0000;
                2: ra = $urandom;
                default: ra = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'($signed($urandom_range(0, 16)) - 8);
                1: rb = 32'h0;
                2: rb = $urandom;
                3: rb = 32'hFFFF_FFFF;
                default: rb = $urandom_range(1, 1000);
            endcase
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 4'($urandom_range(0, 10));
            a     = ra;
            b     = rb;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
